fifo_stream: RTL

//  Parametrised synchronous FIFO with valid/ready handshakes on both sides, an optional

---
 rtl/fifo_stream_if.sv | 22 ++
 rtl/fifo_stream.sv | 106 ++++++++++
 2 files changed

// File: rtl/fifo_stream_if.sv
// Valid/ready stream bundle for both sides of fifo_stream.
// slave is the FIFO's own view; master is the environment driving it.
interface fifo_stream_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  in_vld;
    logic                  in_rdy;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_vld;
    logic                  out_rdy;
    logic [DATA_WIDTH-1:0] out_data;

    modport slave (
        input  in_vld, in_data, out_rdy,
        output in_rdy, out_vld, out_data
    );

    modport master (
        output in_vld, in_data, out_rdy,
        input  in_rdy, out_vld, out_data
    );
endinterface

// File: rtl/fifo_stream.sv
// Synchronous valid/ready FIFO with optional registered output stage,
// occupancy count, almost-full/almost-empty flags and synchronous flush.
// in_rdy depends only on registered state, flush and rst, so back-pressure
// never forms a combinational path from out_rdy to in_rdy.
module fifo_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2,
    parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 1,
    parameter int AE_LEVEL   = 1,
    parameter int OUT_REG    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    fifo_stream_if.slave      bus,
    output logic [ADDR_WIDTH:0] count,
    output logic              almost_full,
    output logic              almost_empty
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CAP   = DEPTH + ((OUT_REG != 0) ? 1 : 0);
    localparam logic [ADDR_WIDTH:0] ONE = 1;

    // Thresholds beyond the capacity can never be reached (or are always met).
    if (ADDR_WIDTH < 1 || AF_LEVEL > CAP || AE_LEVEL > CAP) begin : g_bad_params
        $error("fifo_stream: illegal parameter combination");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic                  mem_full;
    logic                  mem_empty;
    logic                  push;
    logic                  pop;
    logic                  mem_wr;
    logic                  mem_rd;

    assign mem_full  = (wr_ptr == {~rd_ptr[ADDR_WIDTH], rd_ptr[ADDR_WIDTH-1:0]});
    assign mem_empty = (wr_ptr == rd_ptr);
    assign bus.in_rdy = !mem_full && !flush && !rst;
    assign push = bus.in_vld && bus.in_rdy;
    assign pop  = bus.out_vld && bus.out_rdy;

    assign almost_full  = int'(count) >= AF_LEVEL;
    assign almost_empty = int'(count) <= AE_LEVEL;

    if (OUT_REG == 0) begin : g_direct
        assign mem_wr       = push;
        assign mem_rd       = pop;
        assign bus.out_vld  = !mem_empty;
        assign bus.out_data = mem[rd_ptr[ADDR_WIDTH-1:0]];
    end else begin : g_staged
        logic                  stage_vld;
        logic [DATA_WIDTH-1:0] stage_data;
        logic                  stage_load;

        // The stage refills whenever it is empty or being drained this cycle;
        // with nothing in memory, an incoming word bypasses straight into it.
        assign stage_load = !stage_vld || pop;
        assign mem_rd     = stage_load && !mem_empty;
        assign mem_wr     = push && !(stage_load && mem_empty);

        // Output stage register: memory head first, else bypassed push.
        always_ff @(posedge clk) begin
            if (rst || flush) begin
                stage_vld <= 1'b0;
            end else if (stage_load) begin
                if (!mem_empty) begin
                    stage_vld  <= 1'b1;
                    stage_data <= mem[rd_ptr[ADDR_WIDTH-1:0]];
                end else if (push) begin
                    stage_vld  <= 1'b1;
                    stage_data <= bus.in_data;
                end else begin
                    stage_vld <= 1'b0;
                end
            end
        end

        assign bus.out_vld  = stage_vld;
        assign bus.out_data = stage_data;
    end

    // Pointer and occupancy update; rst and flush both return to empty.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (mem_wr) wr_ptr <= wr_ptr + ONE;
            if (mem_rd) rd_ptr <= rd_ptr + ONE;
            case ({push, pop})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_wr) mem[wr_ptr[ADDR_WIDTH-1:0]] <= bus.in_data;
    end
endmodule
